// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared encodings for the snooping cache node
// Contents:
//   LS_*              per-line coherence state encodings
//   OP_*              bus / snoop operation codes
//   fsm_state_t       control FSM states
//   snoop_next_state  line state after a foreign transaction hits the line
package snoop_pkg;

  localparam logic [1:0] LS_INV = 2'b00;  // invalid
  localparam logic [1:0] LS_EXC = 2'b01;  // exclusive, dirty
  localparam logic [1:0] LS_SHR = 2'b10;  // shared, clean
  localparam logic [1:0] LS_CEX = 2'b11;  // exclusive, clean (MESI build only)

  localparam logic [1:0] OP_RD_MISS = 2'b00;
  localparam logic [1:0] OP_WR_MISS = 2'b01;
  localparam logic [1:0] OP_INV     = 2'b10;
  localparam logic [1:0] OP_WB      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_MISS_REQ,
    ST_UPG_REQ,
    ST_FILL
  } fsm_state_t;

  // A foreign read demotes any valid copy to shared; a foreign write or
  // invalidate removes our copy; a foreign write-back never concerns us.
  function automatic logic [1:0] snoop_next_state(input logic [1:0] cur,
                                                  input logic [1:0] op);
    logic [1:0] nxt;
    nxt = cur;
    case (op)
      OP_RD_MISS: nxt = (cur == LS_INV) ? LS_INV : LS_SHR;
      OP_WR_MISS: nxt = LS_INV;
      OP_INV:     nxt = LS_INV;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/snoop_cache_node_line_array.sv
// rtl/snoop_cache_node_line_array.sv - tag/state/data storage with CPU and snoop ports
// Module snoop_line_array
// Ports:
//   i_clock, i_resetn          clock, asynchronous active-low reset
//   i_lk_idx / o_lk_*          CPU-side lookup; state reflects this cycle's snoop
//   i_wr_*                     CPU-side write of tag, state and data
//   i_snoop_valid/op/addr      foreign bus transaction
//   o_snoop_hit, o_snoop_data  registered data supply on a hit to a dirty line
module snoop_line_array
  import snoop_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = ADDR_W - IDX_W
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic [IDX_W-1:0]  i_lk_idx,
  output logic [TAG_W-1:0]  o_lk_tag,
  output logic [1:0]        o_lk_state,
  output logic [DATA_W-1:0] o_lk_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [1:0]        i_wr_state,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_snoop_valid,
  input  logic [1:0]        i_snoop_op,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  output logic              o_snoop_hit,
  output logic [DATA_W-1:0] o_snoop_data
);

  logic [TAG_W-1:0]  r_tag   [LINES];
  logic [1:0]        r_state [LINES];
  logic [DATA_W-1:0] r_data  [LINES];
  logic              r_snoop_hit;
  logic [DATA_W-1:0] r_snoop_data;

  logic [IDX_W-1:0] w_sn_idx;
  logic [TAG_W-1:0] w_sn_tag;
  logic             w_sn_match;
  logic [1:0]       w_sn_next;
  logic             w_sn_supply;

  assign w_sn_idx   = i_snoop_addr[IDX_W-1:0];
  assign w_sn_tag   = i_snoop_addr[ADDR_W-1:IDX_W];
  assign w_sn_match = i_snoop_valid && (r_tag[w_sn_idx] == w_sn_tag) &&
                      (r_state[w_sn_idx] != LS_INV);
  assign w_sn_next  = snoop_next_state(r_state[w_sn_idx], i_snoop_op);
  // Only a dirty owner supplies data; a clean exclusive copy stays silent.
  assign w_sn_supply = w_sn_match && (r_state[w_sn_idx] == LS_EXC) &&
                       ((i_snoop_op == OP_RD_MISS) || (i_snoop_op == OP_WR_MISS));

  // The controller decides on the post-snoop state, so its write is already
  // ordered after the snoop and may simply overwrite the snoop update.
  assign o_lk_tag   = r_tag[i_lk_idx];
  assign o_lk_data  = r_data[i_lk_idx];
  assign o_lk_state = (w_sn_match && (w_sn_idx == i_lk_idx)) ? w_sn_next
                                                             : r_state[i_lk_idx];

  assign o_snoop_hit  = r_snoop_hit;
  assign o_snoop_data = r_snoop_data;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]   <= '0;
        r_state[i] <= LS_INV;
        r_data[i]  <= '0;
      end
      r_snoop_hit  <= 1'b0;
      r_snoop_data <= '0;
    end else begin
      r_snoop_hit  <= w_sn_supply;
      r_snoop_data <= w_sn_supply ? r_data[w_sn_idx] : '0;
      if (w_sn_match) begin
        r_state[w_sn_idx] <= w_sn_next;
      end
      if (i_wr_en) begin
        r_tag[i_wr_idx]   <= i_wr_tag;
        r_state[i_wr_idx] <= i_wr_state;
        r_data[i_wr_idx]  <= i_wr_data;
      end
    end
  end

endmodule

// File: rtl/snoop_cache_node.sv
// rtl/snoop_cache_node.sv - snooping-coherent direct-mapped cache node
// Optional feature macro: SNOOP_MESI_EN (adds the clean-exclusive state 11)
// Ports:
//   i_clock, i_resetn                     clock, asynchronous active-low reset
//   i_cpu_* / o_cpu_ready, o_cpu_rdata    CPU request port, one-cycle ready pulse
//   o_bus_req/op/addr/wdata, i_bus_gnt    registered bus master request
//   i_bus_rvalid, i_bus_rdata             fill data return
//   i_bus_shared                          another node holds the line (MESI only)
//   i_snoop_valid/op/addr                 foreign transaction observed on the bus
//   o_snoop_hit, o_snoop_data             data supplied for a hit on a dirty line
module snoop_cache_node
  import snoop_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_cpu_valid,
  input  logic              i_cpu_write,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_bus_req,
  input  logic              i_bus_gnt,
  output logic [1:0]        o_bus_op,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_rvalid,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_bus_shared,
  input  logic              i_snoop_valid,
  input  logic [1:0]        i_snoop_op,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  output logic              o_snoop_hit,
  output logic [DATA_W-1:0] o_snoop_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

`ifdef SNOOP_MESI_EN
  localparam bit MESI_EN = 1'b1;
`else
  localparam bit MESI_EN = 1'b0;
`endif

  fsm_state_t        r_fsm;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_bus_req;
  logic [1:0]        r_bus_op;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [1:0]        w_lk_state;
  logic [DATA_W-1:0] w_lk_data;
  logic [TAG_W-1:0]  w_cpu_tag;
  logic [TAG_W-1:0]  w_req_tag;
  logic              w_accept;
  logic              w_hit;
  logic              w_silent_wr;
  logic              w_upg_lost;
  logic [1:0]        w_fill_state;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_wr_en;
  logic [TAG_W-1:0]  w_wr_tag;
  logic [1:0]        w_wr_state;
  logic [DATA_W-1:0] w_wr_data;

  // In IDLE the incoming address selects the line; afterwards the latched one.
  assign w_lk_idx  = (r_fsm == ST_IDLE) ? i_cpu_addr[IDX_W-1:0] : r_addr[IDX_W-1:0];
  assign w_cpu_tag = i_cpu_addr[ADDR_W-1:IDX_W];
  assign w_req_tag = r_addr[ADDR_W-1:IDX_W];

  // The CPU still holds valid during the ready pulse; do not re-accept it.
  assign w_accept    = (r_fsm == ST_IDLE) && i_cpu_valid && !r_cpu_ready;
  assign w_hit       = (w_lk_state != LS_INV) && (w_lk_tag == w_cpu_tag);
  assign w_silent_wr = (w_lk_state == LS_EXC) || (MESI_EN && (w_lk_state == LS_CEX));
  assign w_upg_lost  = (w_lk_state == LS_INV) || (w_lk_tag != w_req_tag);

  assign w_fill_state = r_write ? LS_EXC :
                        ((MESI_EN && !i_bus_shared) ? LS_CEX : LS_SHR);
  assign w_fill_data  = r_write ? r_wdata : i_bus_rdata;

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_tag   = w_req_tag;
    w_wr_state = LS_INV;
    w_wr_data  = w_fill_data;
    case (r_fsm)
      ST_IDLE: begin
        if (w_accept && w_hit && i_cpu_write && w_silent_wr) begin
          w_wr_en    = 1'b1;
          w_wr_tag   = w_cpu_tag;
          w_wr_state = LS_EXC;
          w_wr_data  = i_cpu_wdata;
        end
      end
      ST_WB_REQ: begin
        if (i_bus_gnt) begin
          w_wr_en    = 1'b1;
          w_wr_tag   = w_lk_tag;
          w_wr_state = LS_INV;
          w_wr_data  = w_lk_data;
        end
      end
      ST_UPG_REQ: begin
        if (i_bus_gnt) begin
          w_wr_en    = 1'b1;
          w_wr_state = LS_EXC;
          w_wr_data  = r_wdata;
        end
      end
      ST_FILL: begin
        if (i_bus_rvalid) begin
          w_wr_en    = 1'b1;
          w_wr_state = w_fill_state;
        end
      end
      default: ;
    endcase
  end

  snoop_line_array #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .i_clock       (i_clock),
    .i_resetn      (i_resetn),
    .i_lk_idx      (w_lk_idx),
    .o_lk_tag      (w_lk_tag),
    .o_lk_state    (w_lk_state),
    .o_lk_data     (w_lk_data),
    .i_wr_en       (w_wr_en),
    .i_wr_idx      (w_lk_idx),
    .i_wr_tag      (w_wr_tag),
    .i_wr_state    (w_wr_state),
    .i_wr_data     (w_wr_data),
    .i_snoop_valid (i_snoop_valid),
    .i_snoop_op    (i_snoop_op),
    .i_snoop_addr  (i_snoop_addr),
    .o_snoop_hit   (o_snoop_hit),
    .o_snoop_data  (o_snoop_data)
  );

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_fsm       <= ST_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_bus_req   <= 1'b0;
      r_bus_op    <= OP_RD_MISS;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= i_cpu_addr;
            r_write <= i_cpu_write;
            r_wdata <= i_cpu_wdata;
            if (w_hit && !i_cpu_write) begin
              r_cpu_ready <= 1'b1;
              r_cpu_rdata <= w_lk_data;
            end else if (w_hit && w_silent_wr) begin
              r_cpu_ready <= 1'b1;
              r_cpu_rdata <= i_cpu_wdata;
            end else if (w_hit) begin
              r_bus_req   <= 1'b1;
              r_bus_op    <= OP_INV;
              r_bus_addr  <= i_cpu_addr;
              r_bus_wdata <= '0;
              r_fsm       <= ST_UPG_REQ;
            end else if (w_lk_state == LS_EXC) begin
              // Dirty victim: write-back data is frozen here, before any snoop.
              r_bus_req   <= 1'b1;
              r_bus_op    <= OP_WB;
              r_bus_addr  <= {w_lk_tag, i_cpu_addr[IDX_W-1:0]};
              r_bus_wdata <= w_lk_data;
              r_fsm       <= ST_WB_REQ;
            end else begin
              r_bus_req   <= 1'b1;
              r_bus_op    <= i_cpu_write ? OP_WR_MISS : OP_RD_MISS;
              r_bus_addr  <= i_cpu_addr;
              r_bus_wdata <= '0;
              r_fsm       <= ST_MISS_REQ;
            end
          end
        end
        ST_WB_REQ: begin
          // The miss request follows immediately, keeping bus_req asserted.
          if (i_bus_gnt) begin
            r_bus_op    <= r_write ? OP_WR_MISS : OP_RD_MISS;
            r_bus_addr  <= r_addr;
            r_bus_wdata <= '0;
            r_fsm       <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (i_bus_gnt) begin
            r_bus_req  <= 1'b0;
            r_bus_op   <= OP_RD_MISS;
            r_bus_addr <= '0;
            r_fsm      <= ST_FILL;
          end
        end
        ST_UPG_REQ: begin
          if (i_bus_gnt) begin
            r_bus_req   <= 1'b0;
            r_bus_op    <= OP_RD_MISS;
            r_bus_addr  <= '0;
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= r_wdata;
            r_fsm       <= ST_IDLE;
          end else if (w_upg_lost) begin
            // Our shared copy was taken away before the grant: fetch it anew.
            r_bus_op <= OP_WR_MISS;
            r_fsm    <= ST_MISS_REQ;
          end
        end
        ST_FILL: begin
          if (i_bus_rvalid) begin
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= w_fill_data;
            r_fsm       <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_ready = r_cpu_ready;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_bus_req   = r_bus_req;
  assign o_bus_op    = r_bus_op;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_snoop_cache_node.sv
// tb/tb_snoop_cache_node.sv - directed self-checking bench for snoop_cache_node
module tb_snoop_cache_node;

  localparam int LINES  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cpu_valid, cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              bus_req, bus_gnt;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid, bus_shared;
  logic [DATA_W-1:0] bus_rdata;
  logic              snoop_valid;
  logic [1:0]        snoop_op;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_hit;
  logic [DATA_W-1:0] snoop_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  snoop_cache_node #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clock(clk), .i_resetn(resetn),
    .i_cpu_valid(cpu_valid), .i_cpu_write(cpu_write), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata),
    .o_bus_req(bus_req), .i_bus_gnt(bus_gnt), .o_bus_op(bus_op),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata), .i_bus_shared(bus_shared),
    .i_snoop_valid(snoop_valid), .i_snoop_op(snoop_op), .i_snoop_addr(snoop_addr),
    .o_snoop_hit(snoop_hit), .o_snoop_data(snoop_data)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
    cpu_valid = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cpu_valid = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_shared = 1'b1;
    snoop_valid = 0; snoop_op = 0; snoop_addr = 0;
    tick(); tick();
    n_checks++; if (cpu_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", cpu_ready); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus_req); else n_pass++;
    n_checks++; if (bus_op !== 2'b00) $display("FAIL rst_op got %b want 00", bus_op); else n_pass++;
    n_checks++; if (snoop_hit !== 1'b0) $display("FAIL rst_shit got %b want 0", snoop_hit); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b00) $display("FAIL rst_line got %b want 00", dut.u_array.r_state[1]); else n_pass++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    cpu_req(1'b0, 8'h05, 8'h00);
    tick();
    n_checks++; if (bus_req !== 1'b1) $display("FAIL rm_req got %b want 1", bus_req); else n_pass++;
    n_checks++; if (bus_op !== 2'b00) $display("FAIL rm_op got %b want 00", bus_op); else n_pass++;
    n_checks++; if (bus_addr !== 8'h05) $display("FAIL rm_addr got %h want 05", bus_addr); else n_pass++;
    n_checks++; if (cpu_ready !== 1'b0) $display("FAIL rm_early_ready got %b want 0", cpu_ready); else n_pass++;
    tick();
    n_checks++; if (bus_req !== 1'b1) $display("FAIL rm_req_hold got %b want 1", bus_req); else n_pass++;
    bus_gnt = 1'b1;
    tick();
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rm_req_drop got %b want 0", bus_req); else n_pass++;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 8'hA5;
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'hA5) $display("FAIL rm_rdata got %h want a5", cpu_rdata); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b10) $display("FAIL rm_state got %b want 10", dut.u_array.r_state[1]); else n_pass++;
    cpu_valid = 1'b0; bus_rvalid = 1'b0;
    tick();
    n_checks++; if (cpu_ready !== 1'b0) $display("FAIL rm_pulse got %b want 0", cpu_ready); else n_pass++;
  endtask

  task automatic test_read_hit();
    cpu_req(1'b0, 8'h05, 8'h00);
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL rh_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'hA5) $display("FAIL rh_rdata got %h want a5", cpu_rdata); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rh_req got %b want 0", bus_req); else n_pass++;
    cpu_valid = 1'b0;
    tick();
  endtask

  task automatic test_upgrade();
    cpu_req(1'b1, 8'h05, 8'h3C);
    tick();
    n_checks++; if (bus_req !== 1'b1) $display("FAIL up_req got %b want 1", bus_req); else n_pass++;
    n_checks++; if (bus_op !== 2'b10) $display("FAIL up_op got %b want 10", bus_op); else n_pass++;
    n_checks++; if (bus_addr !== 8'h05) $display("FAIL up_addr got %h want 05", bus_addr); else n_pass++;
    bus_gnt = 1'b1;
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL up_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL up_req_drop got %b want 0", bus_req); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b01) $display("FAIL up_state got %b want 01", dut.u_array.r_state[1]); else n_pass++;
    cpu_valid = 1'b0; bus_gnt = 1'b0;
    tick();
  endtask

  task automatic test_snoop_supply();
    snoop_valid = 1'b1; snoop_op = 2'b00; snoop_addr = 8'h05;
    tick();
    n_checks++; if (snoop_hit !== 1'b1) $display("FAIL sn_hit got %b want 1", snoop_hit); else n_pass++;
    n_checks++; if (snoop_data !== 8'h3C) $display("FAIL sn_data got %h want 3c", snoop_data); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b10) $display("FAIL sn_state got %b want 10", dut.u_array.r_state[1]); else n_pass++;
    snoop_op = 2'b01; snoop_addr = 8'h15;
    tick();
    n_checks++; if (snoop_hit !== 1'b0) $display("FAIL sn_tagmiss_hit got %b want 0", snoop_hit); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b10) $display("FAIL sn_tagmiss_state got %b want 10", dut.u_array.r_state[1]); else n_pass++;
    snoop_valid = 1'b0;
    tick();
  endtask

  task automatic test_dirty_evict();
    cpu_req(1'b1, 8'h05, 8'h3C);
    tick();
    bus_gnt = 1'b1;
    tick();
    cpu_valid = 1'b0; bus_gnt = 1'b0;
    tick();
    cpu_req(1'b0, 8'h09, 8'h00);
    tick();
    n_checks++; if (bus_op !== 2'b11) $display("FAIL wb_op got %b want 11", bus_op); else n_pass++;
    n_checks++; if (bus_addr !== 8'h05) $display("FAIL wb_addr got %h want 05", bus_addr); else n_pass++;
    n_checks++; if (bus_wdata !== 8'h3C) $display("FAIL wb_wdata got %h want 3c", bus_wdata); else n_pass++;
    bus_gnt = 1'b1;
    tick();
    n_checks++; if (bus_op !== 2'b00) $display("FAIL wb_next_op got %b want 00", bus_op); else n_pass++;
    n_checks++; if (bus_addr !== 8'h09) $display("FAIL wb_next_addr got %h want 09", bus_addr); else n_pass++;
    n_checks++; if (bus_req !== 1'b1) $display("FAIL wb_next_req got %b want 1", bus_req); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b00) $display("FAIL wb_victim got %b want 00", dut.u_array.r_state[1]); else n_pass++;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 8'h5A;
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL wb_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h5A) $display("FAIL wb_rdata got %h want 5a", cpu_rdata); else n_pass++;
    cpu_valid = 1'b0; bus_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_upgrade_lost();
    cpu_req(1'b0, 8'h05, 8'h00);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 8'h77;
    tick();
    n_checks++; if (cpu_rdata !== 8'h77) $display("FAIL ul_fill got %h want 77", cpu_rdata); else n_pass++;
    cpu_valid = 1'b0; bus_rvalid = 1'b0;
    tick();
    cpu_req(1'b1, 8'h05, 8'hC3);
    tick();
    n_checks++; if (bus_op !== 2'b10) $display("FAIL ul_inv_op got %b want 10", bus_op); else n_pass++;
    snoop_valid = 1'b1; snoop_op = 2'b10; snoop_addr = 8'h05;
    tick();
    n_checks++; if (bus_op !== 2'b01) $display("FAIL ul_wm_op got %b want 01", bus_op); else n_pass++;
    n_checks++; if (bus_addr !== 8'h05) $display("FAIL ul_wm_addr got %h want 05", bus_addr); else n_pass++;
    n_checks++; if (bus_req !== 1'b1) $display("FAIL ul_wm_req got %b want 1", bus_req); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b00) $display("FAIL ul_inv_state got %b want 00", dut.u_array.r_state[1]); else n_pass++;
    snoop_valid = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 8'h00;
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL ul_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b01) $display("FAIL ul_state got %b want 01", dut.u_array.r_state[1]); else n_pass++;
    cpu_valid = 1'b0; bus_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    cpu_req(1'b1, 8'h05, 8'h11);
    snoop_valid = 1'b1; snoop_op = 2'b00; snoop_addr = 8'h05;
    tick();
    n_checks++; if (snoop_hit !== 1'b1) $display("FAIL sc_hit got %b want 1", snoop_hit); else n_pass++;
    n_checks++; if (snoop_data !== 8'hC3) $display("FAIL sc_data got %h want c3", snoop_data); else n_pass++;
    n_checks++; if (bus_op !== 2'b10) $display("FAIL sc_op got %b want 10", bus_op); else n_pass++;
    snoop_valid = 1'b0; bus_gnt = 1'b1;
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL sc_ready got %b want 1", cpu_ready); else n_pass++;
    cpu_valid = 1'b0; bus_gnt = 1'b0;
    tick();
    snoop_valid = 1'b1; snoop_op = 2'b01; snoop_addr = 8'h05;
    tick();
    n_checks++; if (snoop_hit !== 1'b1) $display("FAIL wm_hit got %b want 1", snoop_hit); else n_pass++;
    n_checks++; if (snoop_data !== 8'h11) $display("FAIL wm_data got %h want 11", snoop_data); else n_pass++;
    n_checks++; if (dut.u_array.r_state[1] !== 2'b00) $display("FAIL wm_state got %b want 00", dut.u_array.r_state[1]); else n_pass++;
    snoop_valid = 1'b0;
    tick();
  endtask

  task automatic test_mesi_fill();
    bus_shared = 1'b0;
    cpu_req(1'b0, 8'h06, 8'h00);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 8'h42;
    tick();
    n_checks++; if (cpu_rdata !== 8'h42) $display("FAIL mf_rdata got %h want 42", cpu_rdata); else n_pass++;
    cpu_valid = 1'b0; bus_rvalid = 1'b0; bus_shared = 1'b1;
    tick();
    cpu_req(1'b1, 8'h06, 8'h99);
    tick();
`ifdef SNOOP_MESI_EN
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL mf_ready got %b want 1", cpu_ready); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL mf_req got %b want 0", bus_req); else n_pass++;
    n_checks++; if (dut.u_array.r_state[2] !== 2'b01) $display("FAIL mf_state got %b want 01", dut.u_array.r_state[2]); else n_pass++;
    cpu_valid = 1'b0;
    tick();
`else
    n_checks++; if (bus_req !== 1'b1) $display("FAIL mf_req got %b want 1", bus_req); else n_pass++;
    n_checks++; if (bus_op !== 2'b10) $display("FAIL mf_op got %b want 10", bus_op); else n_pass++;
    n_checks++; if (cpu_ready !== 1'b0) $display("FAIL mf_ready got %b want 0", cpu_ready); else n_pass++;
    bus_gnt = 1'b1;
    tick();
    n_checks++; if (cpu_ready !== 1'b1) $display("FAIL mf_upg_ready got %b want 1", cpu_ready); else n_pass++;
    cpu_valid = 1'b0; bus_gnt = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    cpu_req(1'b0, 8'h21, 8'h00);
    tick();
    n_checks++; if (bus_req !== 1'b1) $display("FAIL rmid_req got %b want 1", bus_req); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rmid_async got %b want 0", bus_req); else n_pass++;
    cpu_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    n_checks++; if (cpu_ready !== 1'b0) $display("FAIL rmid_ready got %b want 0", cpu_ready); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL rmid_req_after got %b want 0", bus_req); else n_pass++;
    n_checks++; if (dut.u_array.r_state[2] !== 2'b00) $display("FAIL rmid_line got %b want 00", dut.u_array.r_state[2]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_upgrade();
    test_snoop_supply();
    test_dirty_evict();
    test_upgrade_lost();
    test_same_cycle();
    test_mesi_fill();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
